// File: rtl/dp_xfer_pkg.sv
// ---------------------------------------------------------------------------
// dp_xfer_pkg
// Shared types for the memory-transfer datapath:
//   xfer_op_t    - 4-bit transfer command codes issued by the control path
//   xfer_state_t - request sequencer states (IDLE / REQ / DONE)
//   is_mem_op()  - true for commands that run a bus transaction
//   is_write_op()- true for commands that drive a bus write
// ---------------------------------------------------------------------------
package dp_xfer_pkg;

    typedef enum logic [3:0] {
        NOP      = 4'd0,
        LD_PC_L  = 4'd1,
        LD_PC_H  = 4'd2,
        LD_SP_L  = 4'd3,
        LD_SP_H  = 4'd4,
        LD_MAR_L = 4'd5,
        LD_MAR_H = 4'd6,
        LD_MDR   = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WR   = 4'd9,
        FETCH    = 4'd10,
        PUSH     = 4'd11,
        POP      = 4'd12,
        PC_INC   = 4'd13,
        SP_INC   = 4'd14,
        SP_DEC   = 4'd15
    } xfer_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } xfer_state_t;

    function automatic logic is_mem_op(input xfer_op_t op);
        return op inside {MEM_RD, MEM_WR, FETCH, PUSH, POP};
    endfunction

    function automatic logic is_write_op(input xfer_op_t op);
        return op inside {MEM_WR, PUSH};
    endfunction

endpackage

// File: rtl/mem_xfer_datapath_if.sv
// ---------------------------------------------------------------------------
// mem_xfer_datapath_if
// Handshaked external memory bus.
//   mem_addr  - bus address (registered by the master)
//   mem_wdata - write data (registered by the master)
//   mem_re    - read request, held until mem_ack
//   mem_we    - write request, held until mem_ack
//   mem_ack   - completion; mem_rdata is valid in the same cycle
//   mem_rdata - read data
// Modports: master (datapath side), slave (memory / MMU side).
// ---------------------------------------------------------------------------
interface mem_xfer_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_re;
    logic              mem_we;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_xfer_datapath_mem_req_fsm.sv
// ---------------------------------------------------------------------------
// mem_req_fsm
// Bus request sequencer for mem_xfer_datapath. Owns the IDLE/REQ/DONE state,
// holds mem_re/mem_we through wait states, and produces the done pulse for
// both register commands and bus commands.
// Optional build macro: MEM_XFER_TIMEOUT_EN adds a wait counter that aborts a
// request after TIMEOUT_CYC cycles without ack and sets a sticky bus_err.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   reg_accept   - a register command was accepted this cycle
//   mem_accept   - a bus command was accepted this cycle
//   write_op     - the accepted bus command is a write
//   mem_ack      - bus completion
//   cmd_ready    - high only in IDLE
//   busy         - high outside IDLE
//   mem_re/we    - bus request strobes
//   commit       - one-cycle strobe: ack seen in REQ, parent updates registers
//   done         - one-cycle retire pulse
//   bus_err      - sticky timeout flag (0 when the timeout is not built)
// ---------------------------------------------------------------------------
module mem_req_fsm
    import dp_xfer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic reg_accept,
    input  logic mem_accept,
    input  logic write_op,
    input  logic mem_ack,
    output logic cmd_ready,
    output logic busy,
    output logic mem_re,
    output logic mem_we,
    output logic commit,
    output logic done,
    output logic bus_err
);

    if (TIMEOUT_CYC < 1) begin : g_timeout_check
        $error("TIMEOUT_CYC must be at least 1");
    end

    xfer_state_t state;
    xfer_state_t state_next;
    logic        write_q;
    logic        reg_done_q;
    logic        timeout;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            write_q    <= 1'b0;
            reg_done_q <= 1'b0;
        end else begin
            state      <= state_next;
            reg_done_q <= reg_accept;
            if (mem_accept) begin
                write_q <= write_op;
            end
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem_accept)         state_next = REQ;
            REQ:     if (mem_ack || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request strobes are decoded from state, so an asynchronous reset drops
    // them in the same cycle.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        mem_re    = (state == REQ) && !write_q;
        mem_we    = (state == REQ) && write_q;
        commit    = (state == REQ) && mem_ack;
        done      = (state == DONE) || reg_done_q;
    end

`ifdef MEM_XFER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Counter sits at zero outside REQ, so it is clear on REQ entry. The
    // request is abandoned on the last allowed wait cycle; an ack in that
    // same cycle still completes normally.
    assign timeout = (state == REQ) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != REQ) begin
                wait_cnt <= '0;
            end else if (!mem_ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_err = err_q;
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

endmodule

// File: rtl/mem_xfer_datapath.sv
// ---------------------------------------------------------------------------
// mem_xfer_datapath
// CPU datapath register block (PC, SP, MAR, MDR, IR) that executes one
// transfer command at a time and drives a handshaked memory bus with
// arbitrary wait states. Address arithmetic wraps modulo 2^ADDR_W.
// Optional build macro: MEM_XFER_TIMEOUT_EN (bus timeout, see mem_req_fsm).
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   cmd_valid/ready    - command handshake (ready only in IDLE)
//   cmd_op             - xfer_op_t command code
//   cmd_data           - operand for load commands
//   done               - one-cycle pulse when a command retires
//   busy               - high outside IDLE
//   pc, sp, mar        - address registers
//   mdr, ir            - data / instruction registers
//   mem                - memory bus (master side)
//   bus_err            - sticky bus timeout flag
// ---------------------------------------------------------------------------
module mem_xfer_datapath
    import dp_xfer_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RST_PC      = '0,
    parameter logic [ADDR_W-1:0] RST_SP      = '0,
    parameter int                TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_op,
    input  logic [DATA_W-1:0]   cmd_data,
    output logic                done,
    output logic                busy,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   sp,
    output logic [ADDR_W-1:0]   mar,
    output logic [DATA_W-1:0]   mdr,
    output logic [DATA_W-1:0]   ir,
    mem_xfer_datapath_if.master mem,
    output logic                bus_err
);

    if (ADDR_W != 2 * DATA_W) begin : g_width_check
        $error("ADDR_W must equal 2*DATA_W");
    end

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    xfer_op_t          op_in;
    xfer_op_t          op_q;
    logic              accept;
    logic              reg_accept;
    logic              mem_accept;
    logic              commit;
    logic              req_re;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;

    assign op_in      = xfer_op_t'(cmd_op);
    assign accept     = cmd_valid && cmd_ready;
    assign mem_accept = accept && is_mem_op(op_in);
    assign reg_accept = accept && !is_mem_op(op_in);

    // Bus address captured at accept; PUSH pre-decrements so the write
    // lands one below the current top of stack.
    always_comb begin
        req_addr = mar;
        case (op_in)
            FETCH:   req_addr = pc;
            PUSH:    req_addr = sp - ADDR_ONE;
            POP:     req_addr = sp;
            default: req_addr = mar;
        endcase
    end

    // accept only happens in IDLE and commit only in REQ, so the branches
    // below are mutually exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RST_PC;
            sp            <= RST_SP;
            mar           <= '0;
            mdr           <= '0;
            ir            <= '0;
            op_q          <= NOP;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else if (reg_accept) begin
            case (op_in)
                LD_PC_L:  pc[DATA_W-1:0]       <= cmd_data;
                LD_PC_H:  pc[ADDR_W-1:DATA_W]  <= cmd_data;
                LD_SP_L:  sp[DATA_W-1:0]       <= cmd_data;
                LD_SP_H:  sp[ADDR_W-1:DATA_W]  <= cmd_data;
                LD_MAR_L: mar[DATA_W-1:0]      <= cmd_data;
                LD_MAR_H: mar[ADDR_W-1:DATA_W] <= cmd_data;
                LD_MDR:   mdr                  <= cmd_data;
                PC_INC:   pc                   <= pc + ADDR_ONE;
                SP_INC:   sp                   <= sp + ADDR_ONE;
                SP_DEC:   sp                   <= sp - ADDR_ONE;
                default:  ;
            endcase
        end else if (mem_accept) begin
            op_q          <= op_in;
            mem.mem_addr  <= req_addr;
            mem.mem_wdata <= mdr;
        end else if (commit) begin
            case (op_q)
                MEM_RD: mdr <= mem.mem_rdata;
                FETCH: begin
                    ir <= mem.mem_rdata;
                    pc <= pc + ADDR_ONE;
                end
                PUSH:   sp <= sp - ADDR_ONE;
                POP: begin
                    mdr <= mem.mem_rdata;
                    sp  <= sp + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

    mem_req_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_req_fsm (
        .clk        (clk),
        .rst        (rst),
        .reg_accept (reg_accept),
        .mem_accept (mem_accept),
        .write_op   (is_write_op(op_in)),
        .mem_ack    (mem.mem_ack),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .mem_re     (req_re),
        .mem_we     (req_we),
        .commit     (commit),
        .done       (done),
        .bus_err    (bus_err)
    );

    assign mem.mem_re = req_re;
    assign mem.mem_we = req_we;

endmodule

// File: tb/tb_mem_xfer_datapath.sv
// ---------------------------------------------------------------------------
// tb_mem_xfer_datapath
// Directed bench for mem_xfer_datapath with a scoreboard: the stimulus
// process queues the expected retire state and bus request for every
// command; independent monitors compare on done pulses and bus requests.
// A memory responder supplies acks after a per-command number of wait
// states. The timeout vector only runs when MEM_XFER_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_xfer_datapath;
    import dp_xfer_pkg::*;

    localparam int          DATA_W      = 8;
    localparam int          ADDR_W      = 16;
    localparam int          TIMEOUT_CYC = 4;
    localparam logic [15:0] RST_PC      = 16'h0100;
    localparam logic [15:0] RST_SP      = 16'hFFFE;

    typedef enum int {M_NORMAL, M_TIMEOUT, M_ABORT} mode_t;

    typedef struct {
        xfer_op_t    op;
        logic [7:0]  data;
        int          dly;
        logic [7:0]  rdata;
        logic [15:0] pc;
        logic [15:0] sp;
        logic [15:0] mar;
        logic [7:0]  mdr;
        logic [7:0]  ir;
        logic        err;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] sp;
        logic [15:0] mar;
        logic [7:0]  mdr;
        logic [7:0]  ir;
        logic        err;
        int          cyc;
    } exp_done_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
        int          start_cyc;
        int          len;
    } exp_bus_t;

    typedef struct {
        int         dly;
        logic [7:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_op = 4'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        cmd_ready, done, busy, bus_err;
    logic [15:0] pc, sp, mar;
    logic [7:0]  mdr, ir;

    mem_xfer_datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_xfer_datapath #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .RST_PC      (RST_PC),
        .RST_SP      (RST_SP),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .done      (done),
        .busy      (busy),
        .pc        (pc),
        .sp        (sp),
        .mar       (mar),
        .mdr       (mdr),
        .ir        (ir),
        .mem       (bus),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    exp_done_t done_q[$];
    exp_bus_t  bus_q[$];
    resp_t     resp_q[$];
    logic      stray_ack = 1'b0;

    // ---------------- memory responder ----------------
    logic  r_active = 1'b0;
    int    r_wait = 0;
    resp_t r_cur;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
    end

    always @(negedge clk) begin
        if (bus.mem_re || bus.mem_we) begin
            if (!r_active) begin
                r_active = 1'b1;
                r_wait   = 0;
                if (resp_q.size() > 0) r_cur = resp_q.pop_front();
                else                   r_cur = '{dly: 100000, rdata: 8'h00};
            end
            if (r_wait == r_cur.dly) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = r_cur.rdata;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 8'hEE;
            end
            r_wait++;
        end else begin
            r_active      = 1'b0;
            bus.mem_ack   = stray_ack;
            bus.mem_rdata = 8'h99;
        end
    end

    // ---------------- retire monitor ----------------
    exp_done_t d_cur;

    always @(negedge clk) begin
        if (!rst && done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                d_cur = done_q.pop_front();
                check("done_cycle", cyc, d_cur.cyc);
                check("pc", {16'd0, pc}, {16'd0, d_cur.pc});
                check("sp", {16'd0, sp}, {16'd0, d_cur.sp});
                check("mar", {16'd0, mar}, {16'd0, d_cur.mar});
                check("mdr", {24'd0, mdr}, {24'd0, d_cur.mdr});
                check("ir", {24'd0, ir}, {24'd0, d_cur.ir});
                check("bus_err", {31'd0, bus_err}, {31'd0, d_cur.err});
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic     req_prev = 1'b0;
    logic     req_now;
    int       req_len = 0;
    logic     b_valid = 1'b0;
    exp_bus_t b_cur;

    always @(negedge clk) begin
        req_now = bus.mem_re || bus.mem_we;
        if (req_now && !req_prev) begin
            req_len = 1;
            if (bus_q.size() == 0) begin
                check("req_unexpected", 32'd1, 32'd0);
                b_valid = 1'b0;
            end else begin
                b_cur   = bus_q.pop_front();
                b_valid = 1'b1;
                check("req_start_cycle", cyc, b_cur.start_cyc);
                check("mem_addr", {16'd0, bus.mem_addr}, {16'd0, b_cur.addr});
                check("mem_we", {31'd0, bus.mem_we}, {31'd0, b_cur.we});
                check("mem_re", {31'd0, bus.mem_re}, {31'd0, !b_cur.we});
                if (b_cur.we) check("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, b_cur.wdata});
            end
        end else if (req_now && req_prev) begin
            req_len++;
            if (b_valid) begin
                check("mem_addr_hold", {16'd0, bus.mem_addr}, {16'd0, b_cur.addr});
                if (b_cur.we) check("mem_wdata_hold", {24'd0, bus.mem_wdata}, {24'd0, b_cur.wdata});
            end
        end else if (!req_now && req_prev) begin
            if (b_valid && b_cur.len != 0) check("req_length", req_len, b_cur.len);
            b_valid = 1'b0;
        end
        req_prev = req_now;
    end

    // ---------------- stimulus ----------------
    function automatic vec_t v(input xfer_op_t op, input logic [7:0] data, input int dly,
                               input logic [7:0] rdata, input logic [15:0] e_pc,
                               input logic [15:0] e_sp, input logic [15:0] e_mar,
                               input logic [7:0] e_mdr, input logic [7:0] e_ir, input logic e_err,
                               input logic [15:0] addr, input logic [7:0] wdata);
        vec_t t;
        t.op = op;   t.data = data; t.dly = dly;  t.rdata = rdata;
        t.pc = e_pc; t.sp = e_sp;   t.mar = e_mar; t.mdr = e_mdr; t.ir = e_ir; t.err = e_err;
        t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    task automatic issue(input vec_t t, input mode_t mode);
        int n;
        int done_cyc;
        int len;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_op    = t.op;
        cmd_data  = t.data;
        if (!is_mem_op(t.op))      done_cyc = cyc + 1;
        else if (mode == M_TIMEOUT) done_cyc = cyc + TIMEOUT_CYC + 1;
        else                        done_cyc = cyc + t.dly + 2;
        if (mode != M_ABORT)
            done_q.push_back('{pc: t.pc, sp: t.sp, mar: t.mar, mdr: t.mdr, ir: t.ir,
                               err: t.err, cyc: done_cyc});
        if (is_mem_op(t.op)) begin
            len = (mode == M_TIMEOUT) ? TIMEOUT_CYC : (mode == M_ABORT) ? 0 : t.dly + 1;
            resp_q.push_back('{dly: t.dly, rdata: t.rdata});
            bus_q.push_back('{addr: t.addr, wdata: t.wdata, we: (t.op == MEM_WR || t.op == PUSH),
                              start_cyc: cyc + 1, len: len});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        while ((done_q.size() != 0 || bus_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_done_queue", done_q.size(), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, {16'd0, pc}, {16'd0, RST_PC});
        check({tag, "_sp"}, {16'd0, sp}, {16'd0, RST_SP});
        check({tag, "_mar"}, {16'd0, mar}, 32'd0);
        check({tag, "_mdr"}, {24'd0, mdr}, 32'd0);
        check({tag, "_ir"}, {24'd0, ir}, 32'd0);
        check({tag, "_mem_addr"}, {16'd0, bus.mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
        check({tag, "_mem_re"}, {31'd0, bus.mem_re}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        //                op        data  dly rdata  pc        sp        mar       mdr    ir     err   addr      wdata
        vecs.push_back(v(LD_MAR_L, 8'h34, 0, 8'h00, 16'h0100, 16'hFFFE, 16'h0034, 8'h00, 8'h00, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(LD_MAR_H, 8'h12, 0, 8'h00, 16'h0100, 16'hFFFE, 16'h1234, 8'h00, 8'h00, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(LD_MDR,   8'hA7, 0, 8'h00, 16'h0100, 16'hFFFE, 16'h1234, 8'hA7, 8'h00, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(MEM_WR,   8'h00, 1, 8'h00, 16'h0100, 16'hFFFE, 16'h1234, 8'hA7, 8'h00, 1'b0, 16'h1234, 8'hA7));
        vecs.push_back(v(MEM_RD,   8'h00, 2, 8'h3C, 16'h0100, 16'hFFFE, 16'h1234, 8'h3C, 8'h00, 1'b0, 16'h1234, 8'h00));
        vecs.push_back(v(LD_PC_L,  8'hFF, 0, 8'h00, 16'h01FF, 16'hFFFE, 16'h1234, 8'h3C, 8'h00, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(LD_PC_H,  8'hFF, 0, 8'h00, 16'hFFFF, 16'hFFFE, 16'h1234, 8'h3C, 8'h00, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(FETCH,    8'h00, 3, 8'hC3, 16'h0000, 16'hFFFE, 16'h1234, 8'h3C, 8'hC3, 1'b0, 16'hFFFF, 8'h00));
        vecs.push_back(v(PC_INC,   8'h00, 0, 8'h00, 16'h0001, 16'hFFFE, 16'h1234, 8'h3C, 8'hC3, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(LD_SP_L,  8'h00, 0, 8'h00, 16'h0001, 16'hFF00, 16'h1234, 8'h3C, 8'hC3, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(LD_SP_H,  8'h00, 0, 8'h00, 16'h0001, 16'h0000, 16'h1234, 8'h3C, 8'hC3, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(LD_MDR,   8'h5A, 0, 8'h00, 16'h0001, 16'h0000, 16'h1234, 8'h5A, 8'hC3, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(PUSH,     8'h00, 0, 8'h00, 16'h0001, 16'hFFFF, 16'h1234, 8'h5A, 8'hC3, 1'b0, 16'hFFFF, 8'h5A));
        vecs.push_back(v(LD_MDR,   8'h00, 0, 8'h00, 16'h0001, 16'hFFFF, 16'h1234, 8'h00, 8'hC3, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(POP,      8'h00, 0, 8'h5A, 16'h0001, 16'h0000, 16'h1234, 8'h5A, 8'hC3, 1'b0, 16'hFFFF, 8'h00));
        vecs.push_back(v(SP_DEC,   8'h00, 0, 8'h00, 16'h0001, 16'hFFFF, 16'h1234, 8'h5A, 8'hC3, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(SP_INC,   8'h00, 0, 8'h00, 16'h0001, 16'h0000, 16'h1234, 8'h5A, 8'hC3, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(NOP,      8'hFF, 0, 8'h00, 16'h0001, 16'h0000, 16'h1234, 8'h5A, 8'hC3, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(SP_INC,   8'h00, 0, 8'h00, 16'h0001, 16'h0001, 16'h1234, 8'h5A, 8'hC3, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(LD_PC_H,  8'h80, 0, 8'h00, 16'h8001, 16'h0001, 16'h1234, 8'h5A, 8'hC3, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(FETCH,    8'h00, 0, 8'h11, 16'h8002, 16'h0001, 16'h1234, 8'h5A, 8'h11, 1'b0, 16'h8001, 8'h00));
        // Issued with a stray ack held high while the bus is idle.
        vecs.push_back(v(LD_MAR_L, 8'h00, 0, 8'h00, 16'h8002, 16'h0001, 16'h1200, 8'h5A, 8'h11, 1'b0, 16'h0000, 8'h00));
        vecs.push_back(v(NOP,      8'h00, 0, 8'h00, 16'h8002, 16'h0001, 16'h1200, 8'h5A, 8'h11, 1'b0, 16'h0000, 8'h00));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        for (int i = 0; i < 21; i++) issue(vecs[i], M_NORMAL);
        stray_ack = 1'b1;
        issue(vecs[21], M_NORMAL);
        issue(vecs[22], M_NORMAL);
        drain();
        stray_ack = 1'b0;

`ifdef MEM_XFER_TIMEOUT_EN
        issue(v(MEM_RD, 8'h00, 255, 8'h77, 16'h8002, 16'h0001, 16'h1200, 8'h5A, 8'h11, 1'b1,
                16'h1200, 8'h00), M_TIMEOUT);
        drain();
        check("bus_err_sticky", {31'd0, bus_err}, 32'd1);
`endif

        // Reset in the middle of a write request.
        issue(v(MEM_WR, 8'h00, 30, 8'h00, 16'h8002, 16'h0001, 16'h1200, 8'h5A, 8'h11, 1'b0,
                16'h1200, 8'h5A), M_ABORT);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("we_before_reset", {31'd0, bus.mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_state("abort");
        @(negedge clk);
        rst = 1'b0;
        resp_q.delete();

        issue(v(PC_INC, 8'h00, 0, 8'h00, 16'h0101, 16'hFFFE, 16'h0000, 8'h00, 8'h00, 1'b0,
                16'h0000, 8'h00), M_NORMAL);
        drain();
        check("bus_queue_empty", bus_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: reached t=%0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_xfer_datapath.md
Name: mem_xfer_datapath

Overview:
Parametrised successor to the CPU datapath register block. It owns PC, SP, MAR, MDR and IR, and executes one transfer command at a time from the control path. Unlike the single-cycle register block it replaces, it drives a handshaked external memory bus with arbitrary wait states, performs FETCH/PUSH/POP address sequencing with wrap-around, and sits between controlpath/ALU and the memory/MMU.

Parameters:
DATA_W, 8, data byte width; ALU result and memory data width.
ADDR_W, 16, address width; must equal 2*DATA_W (elaboration-time assertion).
RST_PC, 0, PC value after reset.
RST_SP, 0, SP value after reset.
TIMEOUT_CYC, 64, maximum wait cycles before a bus abort (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command; high only in IDLE.
cmd_op  in  4  xfer_op_t command code.
cmd_data  in  DATA_W  operand for load commands (ALU output).
done  out  1  one-cycle pulse when a command retires.
busy  out  1  high when not in IDLE.
pc  out  ADDR_W  program counter.
sp  out  ADDR_W  stack pointer.
mar  out  ADDR_W  memory address register.
mdr  out  DATA_W  memory data register.
ir  out  DATA_W  instruction register.
mem_addr  out  ADDR_W  bus address, registered.
mem_wdata  out  DATA_W  bus write data, registered.
mem_re  out  1  read request, held until ack.
mem_we  out  1  write request, held until ack.
mem_ack  in  1  bus completion; rdata valid in the same cycle.
mem_rdata  in  DATA_W  bus read data.
bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst=1): pc=RST_PC, sp=RST_SP; mar, mdr, ir, mem_addr, mem_wdata = 0; mem_re=mem_we=done=bus_err=0; state=IDLE, so cmd_ready=1.
- Accept: a command is accepted when cmd_valid && cmd_ready, in cycle N.
- Command codes 0..15: NOP, LD_PC_L, LD_PC_H, LD_SP_L, LD_SP_H, LD_MAR_L, LD_MAR_H, LD_MDR, MEM_RD, MEM_WR, FETCH, PUSH, POP, PC_INC, SP_INC, SP_DEC.
- Register commands (NOP, LD_*, PC_INC, SP_INC, SP_DEC):
  - The target register updates at the end of cycle N. LD_x_L/H writes only the named half.
  - done=1 in cycle N+1 and the state stays IDLE, so back-to-back acceptance is allowed every cycle.
- Memory commands: on accept, mem_addr, mem_wdata and the op are latched and the state goes IDLE->REQ.
  - MEM_RD: addr=MAR.
  - MEM_WR: addr=MAR, wdata=MDR.
  - FETCH: addr=PC.
  - PUSH: addr=SP-1, wdata=MDR.
  - POP: addr=SP.
- REQ: mem_re or mem_we is asserted from cycle N+1 and held, with mem_addr and mem_wdata stable, until the cycle mem_ack=1. In the ack cycle:
  - MEM_RD/POP: mdr<=mem_rdata.
  - FETCH: ir<=mem_rdata, pc<=pc+1.
  - PUSH: sp<=sp-1.
  - POP: sp<=sp+1.
  - The state goes to DONE.
- DONE: mem_re=mem_we=0 and done=1 for one cycle, then IDLE.
  - Minimum memory latency: accept at N, ack at N+1, done at N+2, next accept at N+3.
- Arithmetic: all increments and decrements are modulo 2^ADDR_W.
  - PC 0xFFFF+1 -> 0x0000.
  - SP 0x0000-1 -> 0xFFFF; PUSH with sp=0 writes address 0xFFFF.
- mem_ack outside REQ is ignored. cmd_valid while busy is not accepted, and cmd_ready=0.
- Reset during REQ aborts the transaction immediately: mem_re/mem_we drop asynchronously and no register update occurs.
- Unused encodings are not applicable; all 16 codes are defined.

Optional Feature:
MEM_XFER_TIMEOUT_EN
- Defined: an 8+ bit wait counter clears on REQ entry and increments each REQ cycle without ack. When it reaches TIMEOUT_CYC:
  - mem_re/mem_we drop.
  - No register updates occur; sp and pc are unchanged.
  - bus_err is set, sticky until reset.
  - The block proceeds to DONE, so done still pulses.
  - An ack in the same cycle as the timeout wins (normal completion).
- Undefined: REQ waits indefinitely, no counter is synthesised, and bus_err is tied to 0.

Decomposition:
- Package dp_xfer_pkg: xfer_op_t enum (4-bit codes above), xfer_state_t {IDLE, REQ, DONE}, and an is_mem_op() function.
- Sub-module mem_req_fsm: owns the state, the request hold, the ack/timeout logic and the done pulse. It outputs a one-cycle commit strobe to the parent register block.

Test Plan:
- Reset with RST_PC=0x0100, RST_SP=0xFFFE -> pc=0x0100, sp=0xFFFE, all other outputs 0, cmd_ready=1.
- LD_MAR_L 0x34 then LD_MAR_H 0x12 in consecutive cycles -> mar=0x1234, two done pulses at N+1 and N+2.
- FETCH with pc=0xFFFF, ack after 3 wait cycles with rdata 0xC3 -> mem_re high for 4 cycles at addr 0xFFFF, ir=0xC3, pc=0x0000, done 1 cycle after ack.
- PUSH with sp=0x0000, mdr=0x5A, immediate ack -> mem_we at addr 0xFFFF, wdata 0x5A, sp=0xFFFF; POP then reads addr 0xFFFF and restores sp=0x0000.
- rst asserted mid-REQ of MEM_WR -> mem_we drops the same cycle, and mar/mdr/sp revert to reset values.
- With MEM_XFER_TIMEOUT_EN and TIMEOUT_CYC=4, MEM_RD with no ack -> request drops after 4 cycles, bus_err=1, mdr unchanged, done pulses once.
